// File: rtl/alu_seq_pkg.sv
// ============================================================================
// Module   : alu_seq_pkg
// Brief    : Shared types and flag indices for the alu sequencer and the alu.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_seq_pkg;

  typedef enum logic [1:0] {
    OP_MUL = 2'b00,
    OP_SUB = 2'b01,
    OP_AND = 2'b10,
    OP_XOR = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_e;

  localparam int FLG_Z = 3;
  localparam int FLG_N = 2;
  localparam int FLG_C = 1;
  localparam int FLG_V = 0;

endpackage : alu_seq_pkg

`default_nettype wire

// File: rtl/alu.sv
// ============================================================================
// Module   : alu
// Brief    : Combinational 4-bit alu (MUL/SUB/AND/XOR) with {Z,N,C,V} flags.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu
  import alu_seq_pkg::*;
(
  input  op_e        sel_i,
  input  logic [3:0] a_i,
  input  logic [1:0] b_i,
  output logic [3:0] y_o,
  output logic [3:0] flags_o
);

  logic [5:0] w_prod;
  logic [4:0] w_diff;
  logic       w_c;
  logic       w_v;

  // B is zero-extended, so signed SUB overflow reduces to A negative, Y positive.
  assign w_prod = {2'b00, a_i} * {4'b0000, b_i};
  assign w_diff = {1'b0, a_i} - {3'b000, b_i};

  always_comb begin
    y_o = 4'h0;
    w_c = 1'b0;
    w_v = 1'b0;
    case (sel_i)
      OP_MUL: begin
        y_o = w_prod[3:0];
        w_c = |w_prod[5:4];
      end
      OP_SUB: begin
        y_o = w_diff[3:0];
        w_c = w_diff[4];
        w_v = a_i[3] & ~w_diff[3];
      end
      OP_AND:  y_o = a_i & {2'b00, b_i};
      OP_XOR:  y_o = a_i ^ {2'b00, b_i};
      default: y_o = 4'h0;
    endcase
  end

  always_comb begin
    flags_o        = 4'h0;
    flags_o[FLG_Z] = (y_o == 4'h0);
    flags_o[FLG_N] = y_o[3];
    flags_o[FLG_C] = w_c;
    flags_o[FLG_V] = w_v;
  end

endmodule : alu

`default_nettype wire

// File: rtl/alu_sequencer.sv
// ============================================================================
// Module   : alu_sequencer
// Brief    : Handshaked command sequencer around the alu with accumulator and
//            sticky carry/overflow flags.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int         EXEC_CYCLES = 1,
  parameter logic [3:0] ACC_RESET   = 4'h0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [3:0] cmd_a,
  input  logic [1:0] cmd_b,
  input  logic       cmd_use_acc,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [3:0] rsp_y,
  output logic [3:0] rsp_flags,
  output logic [3:0] acc,
  output logic       sticky_c,
  output logic       sticky_v,
  input  logic       sticky_clr,
  output logic       busy
);

  localparam logic [3:0] C_LAST_CNT = 4'(EXEC_CYCLES - 1);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  op_e        op_q, op_d;
  logic [3:0] a_q, a_d;
  logic [1:0] b_q, b_d;
  logic [3:0] y_q, y_d;
  logic [3:0] flags_q, flags_d;
  logic [3:0] acc_q, acc_d;
  logic       sc_q, sc_d;
  logic       sv_q, sv_d;
  logic       w_capture;

  logic [3:0] w_alu_y;
  logic [3:0] w_alu_flags;

  // The alu sees only the operand registers, so cmd_* may change freely during EXEC.
  alu u_alu (
    .sel_i   (op_q),
    .a_i     (a_q),
    .b_i     (b_q),
    .y_o     (w_alu_y),
    .flags_o (w_alu_flags)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    y_d       = y_q;
    flags_d   = flags_q;
    acc_d     = acc_q;
    sc_d      = sc_q;
    sv_d      = sv_q;
    w_capture = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          op_d    = op_e'(cmd_op);
          a_d     = cmd_use_acc ? acc_q : cmd_a;
          b_d     = cmd_b;
          cnt_d   = 4'h0;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        cnt_d = cnt_q + 4'h1;
        if (cnt_q == C_LAST_CNT) begin
          w_capture = 1'b1;
          y_d       = w_alu_y;
          flags_d   = w_alu_flags;
          acc_d     = w_alu_y;
          state_d   = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // A set in the same cycle as a clear takes priority.
    if (sticky_clr) begin
      sc_d = 1'b0;
      sv_d = 1'b0;
    end
    if (w_capture && w_alu_flags[FLG_C]) sc_d = 1'b1;
    if (w_capture && w_alu_flags[FLG_V]) sv_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'h0;
      op_q    <= OP_MUL;
      a_q     <= 4'h0;
      b_q     <= 2'b00;
      y_q     <= 4'h0;
      flags_q <= 4'h0;
      acc_q   <= ACC_RESET;
      sc_q    <= 1'b0;
      sv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      y_q     <= y_d;
      flags_q <= flags_d;
      acc_q   <= acc_d;
      sc_q    <= sc_d;
      sv_q    <= sv_d;
    end
  end

  assign cmd_ready = (state_q == S_IDLE);
  assign rsp_valid = (state_q == S_RESP);
  assign busy      = (state_q != S_IDLE);
  assign rsp_y     = y_q;
  assign rsp_flags = flags_q;
  assign acc       = acc_q;
  assign sticky_c  = sc_q;
  assign sticky_v  = sv_q;

endmodule : alu_sequencer

`default_nettype wire
